riscv_lsu: RTL and testbench

Load/store unit sitting directly upstream of the byte-laned data memory. It accepts one load/store request at a time from the execute stage and drives the memory's address, access-size, write-data and read/write-enable pins. It places store data into the correct byte lanes and extracts, sign-extends or zero-extends load data. Misaligned accesses are split into sequential byte accesses; aligned accesses take a single memory cycle.

---
 rtl/riscv_lsu_pkg.sv | 30 +++
 rtl/riscv_lsu_load_ext.sv | 29 ++
 rtl/riscv_lsu.sv | 178 +++++++++++++++++
 tb/tb_riscv_lsu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// rtl/riscv_lsu_pkg.sv - shared constants, state encoding and decode helpers for the load/store unit
package riscv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] BY_BYTE = 2'b00;
    localparam logic [1:0] BY_HALF = 2'b01;
    localparam logic [1:0] BY_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_t;

    // 011 and 11x are never legal; stores only know b/h/w
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        f3_illegal = (f3[1:0] == 2'b11) || (f3[2] && (we || f3[1]));
    endfunction

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        is_misaligned = ((size == 2'b01) && a[0]) || ((size == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/riscv_lsu_load_ext.sv
// rtl/riscv_lsu_load_ext.sv - load lane select with sign/zero extension
module riscv_lsu_load_ext
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = data[{lane, 3'b000} +: 8];
    assign sel_half = lane[1] ? data[31:16] : data[15:0];

    // Extend the selected lane according to the load flavour
    always_comb begin
        result = data;
        case (funct3)
            F3_B:    result = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    result = {{16{sel_half[15]}}, sel_half};
            F3_BU:   result = {24'd0, sel_byte};
            F3_HU:   result = {16'd0, sel_half};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit driving a byte-laned data memory, with optional misaligned splitting
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int SPLIT_MISALIGNED = 1,
    parameter int ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_by,
    output logic [31:0]       mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              split_q;
    logic              err_q;
    logic [1:0]        cnt_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              req_illegal;
    logic              req_mis;
    logic              req_err;
    logic [ADDR_W-1:0] cur_addr;
    logic [1:0]        last_cnt;
    logic              split_last;
    logic [7:0]        lane_byte;
    logic [31:0]       merge_next;
    logic [31:0]       ext_data;
    logic [1:0]        ext_lane;
    logic [31:0]       ext_rdata;

    assign accept      = req_valid && (state_q == ST_IDLE);
    assign req_illegal = f3_illegal(req_we, req_funct3);
    assign req_mis     = is_misaligned(req_funct3[1:0], req_addr[1:0]);
    assign req_err     = req_illegal || (req_mis && (SPLIT_MISALIGNED == 0));

    // Split accesses walk byte by byte; the address wraps naturally at ADDR_W bits
    assign cur_addr   = addr_q + ADDR_W'(cnt_q);
    assign last_cnt   = (f3_q[1:0] == 2'b10) ? 2'd3 : 2'd1;
    assign split_last = (cnt_q == last_cnt);
    assign lane_byte  = mem_rdata[{cur_addr[1:0], 3'b000} +: 8];
    assign merge_next = merge_q | ({24'd0, lane_byte} << {cnt_q, 3'b000});

    // Merged data is already right-justified, so its extension uses lane 0
    assign ext_data = split_q ? merge_next : mem_rdata;
    assign ext_lane = split_q ? 2'b00 : addr_q[1:0];

    riscv_lsu_load_ext u_load_ext (
        .data   (ext_data),
        .lane   (ext_lane),
        .funct3 (f3_q),
        .result (ext_rdata)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus memory and response pins
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        mem_addr   = '0;
        mem_by     = BY_BYTE;
        mem_wdata  = 32'd0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_re = !we_q;
                mem_we = we_q;
                if (split_q) begin
                    mem_addr  = cur_addr;
                    mem_by    = BY_BYTE;
                    mem_wdata = {4{wdata_q[{cnt_q, 3'b000} +: 8]}};
                    if (split_last) begin
                        state_d = ST_RESP;
                    end
                end else begin
                    mem_addr = addr_q;
                    case (f3_q[1:0])
                        2'b00: begin
                            mem_by    = BY_BYTE;
                            mem_wdata = {4{wdata_q[7:0]}};
                        end
                        2'b01: begin
                            mem_by    = BY_HALF;
                            mem_wdata = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            mem_by    = BY_WORD;
                            mem_wdata = wdata_q;
                        end
                    endcase
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, byte counter, merge register and load result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 2'd0;
            merge_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                split_q <= req_mis && !req_illegal;
                err_q   <= req_err;
                cnt_q   <= 2'd0;
                merge_q <= 32'd0;
                rdata_q <= 32'd0;
            end else if (state_q == ST_ACCESS) begin
                if (split_q) begin
                    cnt_q   <= cnt_q + 2'd1;
                    merge_q <= merge_next;
                    if (split_last && !we_q) begin
                        rdata_q <= ext_rdata;
                    end
                end else if (!we_q) begin
                    rdata_q <= ext_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - directed table-driven bench for riscv_lsu with a byte-laned memory model
module tb_riscv_lsu;

    logic        clk;
    logic        rst;

    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, mem_re, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_by;

    logic        ns_valid, ns_we;
    logic [2:0]  ns_funct3;
    logic [31:0] ns_addr, ns_wdata;
    logic        ns_ready, ns_resp_valid, ns_resp_err, ns_mem_re, ns_mem_we;
    logic [31:0] ns_resp_rdata, ns_mem_addr, ns_mem_wdata, ns_mem_rdata;
    logic [1:0]  ns_mem_by;

    logic [31:0] mem [0:255];
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;

    int n_pass;
    int n_total;

    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic [1:0]  log_by[$];

    logic        sel_ns;
    logic        c_ready, c_resp_valid, c_err, c_re, c_we;
    logic [31:0] c_rdata, c_addr, c_wdata;
    logic [1:0]  c_by;

    riscv_lsu #(.SPLIT_MISALIGNED(1), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_by(mem_by), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    riscv_lsu #(.SPLIT_MISALIGNED(0), .ADDR_W(32)) dut_ns (
        .clk(clk), .rst(rst),
        .req_valid(ns_valid), .req_ready(ns_ready), .req_we(ns_we),
        .req_funct3(ns_funct3), .req_addr(ns_addr), .req_wdata(ns_wdata),
        .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata), .resp_err(ns_resp_err),
        .mem_addr(ns_mem_addr), .mem_by(ns_mem_by), .mem_wdata(ns_mem_wdata),
        .mem_re(ns_mem_re), .mem_we(ns_mem_we), .mem_rdata(ns_mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    assign c_ready      = sel_ns ? ns_ready      : req_ready;
    assign c_resp_valid = sel_ns ? ns_resp_valid : resp_valid;
    assign c_err        = sel_ns ? ns_resp_err   : resp_err;
    assign c_re         = sel_ns ? ns_mem_re     : mem_re;
    assign c_we         = sel_ns ? ns_mem_we     : mem_we;
    assign c_rdata      = sel_ns ? ns_resp_rdata : resp_rdata;
    assign c_addr       = sel_ns ? ns_mem_addr   : mem_addr;
    assign c_wdata      = sel_ns ? ns_mem_wdata  : mem_wdata;
    assign c_by         = sel_ns ? ns_mem_by     : mem_by;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (mem_we) begin
            case (mem_by)
                2'b00: mem[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[{mem_addr[1:0], 3'b000} +: 8];
                2'b01: begin
                    if (mem_addr[1]) mem[mem_addr[9:2]][31:16] <= mem_wdata[31:16];
                    else             mem[mem_addr[9:2]][15:0]  <= mem_wdata[15:0];
                end
                default: mem[mem_addr[9:2]] <= mem_wdata;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic run_req(input bit ns, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er,
                           output int lat, output int acc);
        bit both_seen;
        bit ready_seen;
        log_addr.delete(); log_wdata.delete(); log_by.delete();
        both_seen = 0; ready_seen = 0;
        @(negedge clk);
        sel_ns = ns;
        chk("req_ready_idle", {31'd0, c_ready}, 32'd1);
        if (ns) begin
            ns_valid = 1'b1; ns_we = we; ns_funct3 = f3; ns_addr = addr; ns_wdata = wdata;
        end else begin
            req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; ns_valid = 1'b0;
        lat = 1; acc = 0; rd = 32'd0; er = 1'b0;
        while (lat <= 12) begin
            if (c_ready) ready_seen = 1;
            if (c_resp_valid) break;
            if (c_re || c_we) begin
                acc++;
                log_addr.push_back(c_addr);
                log_wdata.push_back(c_wdata);
                log_by.push_back(c_by);
            end
            if (c_re && c_we) both_seen = 1;
            @(posedge clk); #1;
            lat++;
        end
        if (lat > 12) chk("resp_timeout", 32'(lat), 32'd0);
        rd = c_rdata;
        er = c_err;
        chk("re_we_exclusive", {31'd0, both_seen}, 32'd0);
        chk("ready_low_while_busy", {31'd0, ready_seen}, 32'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          ns;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_acc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, acc;
        bit          saw_resp;

        clk = 0; rst = 1; bd_we = 0; bd_idx = 0; bd_data = 0; sel_ns = 0;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        ns_valid = 0; ns_we = 0; ns_funct3 = 0; ns_addr = 0; ns_wdata = 0;
        ns_mem_rdata = 32'h8899AABB;
        n_pass = 0; n_total = 0;

        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_en", {30'd0, mem_re, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_by", {30'd0, mem_by}, 32'd0);
        @(negedge clk); rst = 0;

        poke(8'd64, 32'h8899AABB);
        poke(8'd65, 32'h00112233);
        poke(8'd66, 32'h00000000);
        poke(8'd67, 32'h00000000);
        poke(8'd255, 32'h80112233);
        poke(8'd0, 32'h445566F7);

        vecs.push_back('{0, 1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b0, 3'b100, 32'h101, 32'h0,        32'h000000AA, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b0, 3'b001, 32'h101, 32'h0,        32'hFFFF99AA, 1'b0, 3, 2});
        vecs.push_back('{0, 1'b0, 3'b101, 32'h102, 32'h0,        32'h00008899, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFF8899, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h103, 32'h0,        32'h11223388, 1'b0, 5, 4});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h100, 32'h0,        32'h8899AABB, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h00000000, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h100, 32'h0,        32'h1234AABB, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b1, 3'b000, 32'h107, 32'hFFFFFF7F, 32'h00000000, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b0, 3'b000, 32'h107, 32'h0,        32'h0000007F, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b1, 3'b010, 32'h105, 32'hCAFEF00D, 32'h00000000, 1'b0, 5, 4});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h104, 32'h0,        32'hFEF00D33, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h108, 32'h0,        32'h000000CA, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b0, 3'b101, 32'h107, 32'h0,        32'h0000CAFE, 1'b0, 3, 2});
        vecs.push_back('{0, 1'b1, 3'b010, 32'h10C, 32'h12345678, 32'h00000000, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h10C, 32'h0,        32'h12345678, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b0, 3'b000, 32'h10E, 32'h0,        32'h00000034, 1'b0, 2, 1});
        vecs.push_back('{0, 1'b0, 3'b011, 32'h100, 32'h0,        32'h00000000, 1'b1, 1, 0});
        vecs.push_back('{0, 1'b0, 3'b110, 32'h100, 32'h0,        32'h00000000, 1'b1, 1, 0});
        vecs.push_back('{0, 1'b0, 3'b111, 32'h100, 32'h0,        32'h00000000, 1'b1, 1, 0});
        vecs.push_back('{0, 1'b1, 3'b100, 32'h100, 32'h55,       32'h00000000, 1'b1, 1, 0});
        vecs.push_back('{0, 1'b1, 3'b011, 32'h100, 32'h55,       32'h00000000, 1'b1, 1, 0});
        vecs.push_back('{0, 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0,   32'hFFFFF780, 1'b0, 3, 2});
        vecs.push_back('{0, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0,   32'h66F78011, 1'b0, 5, 4});
        vecs.push_back('{1, 1'b0, 3'b010, 32'h103, 32'h0,        32'h00000000, 1'b1, 1, 0});
        vecs.push_back('{1, 1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 1});
        vecs.push_back('{1, 1'b0, 3'b001, 32'h101, 32'h0,        32'h00000000, 1'b1, 1, 0});
        vecs.push_back('{1, 1'b0, 3'b010, 32'h100, 32'h0,        32'h8899AABB, 1'b0, 2, 1});

        for (int i = 0; i < vecs.size(); i++) begin
            run_req(vecs[i].ns, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, acc);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_mem_cycles", i), 32'(acc), 32'(vecs[i].exp_acc));
        end

        // Aligned halfword store: lane placement and pin values
        poke(8'd64, 32'h8899AABB);
        run_req(0, 1'b1, 3'b001, 32'h102, 32'h00001234, rd, er, lat, acc);
        chk("sh_mem_by", {30'd0, log_by[0]}, 32'd1);
        chk("sh_mem_wdata", log_wdata[0], 32'h12341234);
        chk("sh_mem_addr", log_addr[0], 32'h102);
        chk("sh_mem_word", mem[64], 32'h1234AABB);

        // Wrapping halfword load: address sequence
        run_req(0, 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, rd, er, lat, acc);
        chk("wrap_addr0", log_addr[0], 32'hFFFFFFFF);
        chk("wrap_addr1", log_addr[1], 32'h00000000);
        chk("wrap_rdata", rd, 32'hFFFFF780);

        // Misaligned word store: per-byte replication and addresses
        run_req(0, 1'b1, 3'b010, 32'h105, 32'hCAFEF00D, rd, er, lat, acc);
        chk("split_wdata0", log_wdata[0], 32'h0D0D0D0D);
        chk("split_wdata3", log_wdata[3], 32'hCACACACA);
        chk("split_addr3", log_addr[3], 32'h108);
        chk("split_by3", {30'd0, log_by[3]}, 32'd0);

        // Reset in the middle of a split store
        poke(8'd64, 32'h00000000);
        poke(8'd65, 32'h00000000);
        @(negedge clk);
        sel_ns = 0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h101; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        saw_resp = 0;
        @(posedge clk); #1;
        if (resp_valid) saw_resp = 1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (resp_valid || mem_we) saw_resp = 1;
        end
        chk("abort_no_resp", {31'd0, saw_resp}, 32'd0);
        chk("abort_word0", mem[64], 32'h00BEEF00);
        chk("abort_word1", mem[65], 32'h00000000);
        chk("abort_ready_after", {31'd0, req_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
